// File: rtl/shift_reg_sequencer_pkg.sv
// Shared types and helpers for the shift-register command sequencer.
// Optional back-to-back mode is selected with SHIFT_REG_SEQUENCER_BACK_TO_BACK_EN.
package shift_reg_sequencer_pkg;

   localparam int DEFAULT_REG_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Shifting more than the register width is equivalent to shifting it full width.
   function automatic int unsigned clamp_shift_cnt(input int unsigned cnt,
                                                   input int unsigned max_cnt);
      return (cnt > max_cnt) ? max_cnt : cnt;
   endfunction

endpackage

// File: rtl/shift_seq_counter.sv
// Loadable down-counter that paces the SHIFT state; flags report zero and one.
module shift_seq_counter #(
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_en,
   input  logic [CNT_WIDTH-1:0] load_val,
   input  logic                 dec_en,
   output logic                 is_zero,
   output logic                 is_one
);

   logic [CNT_WIDTH-1:0] count_q;
   logic [CNT_WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load_en) begin
         count_d = load_val;
      end else if (dec_en && (count_q != '0)) begin
         count_d = count_q - CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign is_zero = (count_q == '0);
   assign is_one  = (count_q == CNT_WIDTH'(1));

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for a left/right shift register with parallel load.
// Define SHIFT_REG_SEQUENCER_BACK_TO_BACK_EN to accept a new command in the DONE cycle.
module shift_reg_sequencer
   import shift_reg_sequencer_pkg::*;
#(
   parameter  int REG_WIDTH = DEFAULT_REG_WIDTH,
   localparam int CNT_WIDTH = $clog2(REG_WIDTH) + 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [REG_WIDTH-1:0] cmd_data,
   input  logic                 cmd_dir,
   input  logic [CNT_WIDTH-1:0] cmd_shift_cnt,
   output logic                 load,
   output logic                 shift_left_right,
   output logic [REG_WIDTH-1:0] data_in,
   output logic                 shift_en,
   output logic                 busy,
   output logic                 done,
   output logic [1:0]           state_dbg
);

   // Handshake: a command transfers on the rising edge where cmd_valid and
   // cmd_ready are both high; cmd_* are sampled only on that edge.

   state_e               state_q, state_d;
   logic                 load_q, load_d;
   logic                 shift_en_q, shift_en_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 slr_q, slr_d;
   logic [REG_WIDTH-1:0] data_in_q, data_in_d;

   logic                 accept;
   logic                 cnt_load;
   logic                 cnt_dec;
   logic                 cnt_is_zero;
   logic                 cnt_is_one;
   logic [CNT_WIDTH-1:0] cnt_clamped;

   assign cnt_clamped = CNT_WIDTH'(clamp_shift_cnt(32'(cmd_shift_cnt), REG_WIDTH));

`ifdef SHIFT_REG_SEQUENCER_BACK_TO_BACK_EN
   assign cmd_ready = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && !reset;
`else
   assign cmd_ready = (state_q == ST_IDLE) && !reset;
`endif

   assign accept = cmd_valid && cmd_ready;

   shift_seq_counter #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_counter (
      .clk      (clk),
      .reset    (reset),
      .load_en  (cnt_load),
      .load_val (cnt_clamped),
      .dec_en   (cnt_dec),
      .is_zero  (cnt_is_zero),
      .is_one   (cnt_is_one)
   );

   always_comb begin
      state_d   = state_q;
      data_in_d = data_in_q;
      slr_d     = slr_q;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_LOAD;
               data_in_d = cmd_data;
               slr_d     = cmd_dir;
               cnt_load  = 1'b1;
            end
         end
         ST_LOAD: begin
            state_d = cnt_is_zero ? ST_DONE : ST_SHIFT;
         end
         ST_SHIFT: begin
            cnt_dec = 1'b1;
            if (cnt_is_one) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
`ifdef SHIFT_REG_SEQUENCER_BACK_TO_BACK_EN
            if (accept) begin
               state_d   = ST_LOAD;
               data_in_d = cmd_data;
               slr_d     = cmd_dir;
               cnt_load  = 1'b1;
            end
`endif
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Direction is only meaningful while a command is active; data_in keeps its last value.
      if (state_d == ST_IDLE) begin
         slr_d = 1'b0;
      end

      load_d     = (state_d == ST_LOAD);
      shift_en_d = (state_d == ST_SHIFT);
      done_d     = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         load_q     <= 1'b0;
         shift_en_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         slr_q      <= 1'b0;
         data_in_q  <= '0;
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         shift_en_q <= shift_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         slr_q      <= slr_d;
         data_in_q  <= data_in_d;
      end
   end

   assign load             = load_q;
   assign shift_en         = shift_en_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign shift_left_right = slr_q;
   assign data_in          = data_in_q;
   assign state_dbg        = state_q;

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Directed bench for shift_reg_sequencer with hand-computed expectations.
module tb_shift_reg_sequencer;

   localparam int W  = 8;
   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [W-1:0]  cmd_data;
   logic          cmd_dir;
   logic [CW-1:0] cmd_shift_cnt;
   logic          load;
   logic          shift_left_right;
   logic [W-1:0]  data_in;
   logic          shift_en;
   logic          busy;
   logic          done;
   logic [1:0]    state_dbg;

   int vec_cnt;
   int err_cnt;
   logic [W-1:0] exp_q[$];

   shift_reg_sequencer dut (
      .clk              (clk),
      .reset            (reset),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_data         (cmd_data),
      .cmd_dir          (cmd_dir),
      .cmd_shift_cnt    (cmd_shift_cnt),
      .load             (load),
      .shift_left_right (shift_left_right),
      .data_in          (data_in),
      .shift_en         (shift_en),
      .busy             (busy),
      .done             (done),
      .state_dbg        (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_load"}, {31'b0, load}, 32'd0);
      chk({tag, "_shift_en"}, {31'b0, shift_en}, 32'd0);
      chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
      chk({tag, "_done"}, {31'b0, done}, 32'd0);
      chk({tag, "_slr"}, {31'b0, shift_left_right}, 32'd0);
   endtask

   // Issue one command and follow it cycle by cycle to idle; exp_n is the hand-clamped count.
   task automatic run_cmd(input logic [W-1:0] d, input logic dir, input logic [CW-1:0] cnt,
                          input int exp_n);
      int guard;
      logic [W-1:0] exp_d;
      exp_q.push_back(d);
      cmd_data      = d;
      cmd_dir       = dir;
      cmd_shift_cnt = cnt;
      cmd_valid     = 1'b1;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         tick();
         guard++;
      end
      chk("ready_wait", {31'b0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      exp_d = exp_q.pop_front();
      chk("load", {31'b0, load}, 32'd1);
      chk("load_data_in", {24'b0, data_in}, {24'b0, exp_d});
      chk("load_dir", {31'b0, shift_left_right}, {31'b0, dir});
      chk("load_busy", {31'b0, busy}, 32'd1);
      chk("load_shift_en", {31'b0, shift_en}, 32'd0);
      chk("load_ready", {31'b0, cmd_ready}, 32'd0);
      for (int i = 0; i < exp_n; i++) begin
         tick();
         chk("shift_en", {31'b0, shift_en}, 32'd1);
         chk("shift_load", {31'b0, load}, 32'd0);
         chk("shift_dir", {31'b0, shift_left_right}, {31'b0, dir});
         chk("shift_done", {31'b0, done}, 32'd0);
         chk("shift_data_in", {24'b0, data_in}, {24'b0, exp_d});
      end
      tick();
      chk("done", {31'b0, done}, 32'd1);
      chk("done_shift_en", {31'b0, shift_en}, 32'd0);
      chk("done_busy", {31'b0, busy}, 32'd1);
      chk("done_data_in", {24'b0, data_in}, {24'b0, exp_d});
      tick();
      chk_idle_outputs("after");
      chk("after_ready", {31'b0, cmd_ready}, 32'd1);
      chk("after_data_in", {24'b0, data_in}, {24'b0, exp_d});
   endtask

   initial begin
      vec_cnt       = 0;
      err_cnt       = 0;
      reset         = 1'b1;
      cmd_valid     = 1'b0;
      cmd_data      = '0;
      cmd_dir       = 1'b0;
      cmd_shift_cnt = '0;
      tick();
      tick();
      chk("reset_ready", {31'b0, cmd_ready}, 32'd0);
      chk_idle_outputs("reset");
      chk("reset_data_in", {24'b0, data_in}, 32'd0);
      reset = 1'b0;
      #1;
      chk("post_reset_ready", {31'b0, cmd_ready}, 32'd1);

      // left shift by 3, plain zero count, clamp, exact full width
      run_cmd(8'hA5, 1'b1, 4'd3, 3);
      run_cmd(8'h01, 1'b0, 4'd0, 0);
      run_cmd(8'h5A, 1'b0, 4'd15, 8);
      run_cmd(8'hF0, 1'b1, 4'd8, 8);
      run_cmd(8'h81, 1'b0, 4'd9, 8);

      // reset during the second shift cycle
      cmd_data = 8'h77; cmd_dir = 1'b1; cmd_shift_cnt = 4'd5; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("rst_mid_load", {31'b0, load}, 32'd1);
      tick();
      tick();
      chk("rst_mid_shift2", {31'b0, shift_en}, 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_mid_ready_low", {31'b0, cmd_ready}, 32'd0);
      tick();
      chk_idle_outputs("rst_mid");
      chk("rst_mid_data_in", {24'b0, data_in}, 32'd0);
      chk("rst_mid_state", {30'b0, state_dbg}, 32'd0);
      reset = 1'b0;
      #1;
      chk("rst_mid_ready", {31'b0, cmd_ready}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("rst_mid_no_done", {31'b0, done}, 32'd0);
      end

      // valid held across busy; second command must wait for ready
      cmd_data = 8'h3C; cmd_dir = 1'b0; cmd_shift_cnt = 4'd2; cmd_valid = 1'b1;
      tick();
      chk("hold_load1", {31'b0, load}, 32'd1);
      cmd_data = 8'hC3; cmd_dir = 1'b1; cmd_shift_cnt = 4'd1;
      tick();
      chk("hold_data_ignored1", {24'b0, data_in}, 32'h3C);
      tick();
      chk("hold_data_ignored2", {24'b0, data_in}, 32'h3C);
      chk("hold_dir_ignored", {31'b0, shift_left_right}, 32'd0);
      tick();
      chk("hold_done1", {31'b0, done}, 32'd1);
`ifdef SHIFT_REG_SEQUENCER_BACK_TO_BACK_EN
      chk("hold_ready_in_done", {31'b0, cmd_ready}, 32'd1);
      tick();
      cmd_valid = 1'b0;
      chk("b2b_load2", {31'b0, load}, 32'd1);
      chk("b2b_done_cleared", {31'b0, done}, 32'd0);
      chk("b2b_data2", {24'b0, data_in}, 32'hC3);
      chk("b2b_dir2", {31'b0, shift_left_right}, 32'd1);
`else
      chk("hold_ready_in_done", {31'b0, cmd_ready}, 32'd0);
      tick();
      chk("gap_idle_busy", {31'b0, busy}, 32'd0);
      chk("gap_idle_ready", {31'b0, cmd_ready}, 32'd1);
      chk("gap_idle_data", {24'b0, data_in}, 32'h3C);
      tick();
      cmd_valid = 1'b0;
      chk("gap_load2", {31'b0, load}, 32'd1);
      chk("gap_data2", {24'b0, data_in}, 32'hC3);
      chk("gap_dir2", {31'b0, shift_left_right}, 32'd1);
`endif
      tick();
      chk("second_shift", {31'b0, shift_en}, 32'd1);
      tick();
      chk("second_done", {31'b0, done}, 32'd1);
      tick();
      chk("second_idle", {31'b0, busy}, 32'd0);

      // reset and valid together: no accept
      reset = 1'b1;
      cmd_data = 8'hEE; cmd_dir = 1'b1; cmd_shift_cnt = 4'd2; cmd_valid = 1'b1;
      tick();
      reset = 1'b0;
      cmd_valid = 1'b0;
      chk("rv_busy", {31'b0, busy}, 32'd0);
      chk("rv_load", {31'b0, load}, 32'd0);
      chk("rv_data_in", {24'b0, data_in}, 32'd0);
      tick();
      chk("rv_busy_next", {31'b0, busy}, 32'd0);
      chk("rv_load_next", {31'b0, load}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
